uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and state encodings for the UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_pkg;

    // Oversampling ratio: sample ticks per bit period.
    localparam int OVS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    // Tick count at which the start bit midpoint is reached.
    localparam logic [3:0] START_MID = 4'd7;
    // Last tick of a full data bit period.
    localparam logic [3:0] BIT_LAST  = 4'(OVS - 1);

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clocks from d to q.
// Backpressure: none.
// Ports: clock/reset (async active-high, forces both flops to RST_VAL),
//        d (asynchronous input), q (synchronized output).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, configurable data/stop length.
// Latency: rx_done_tick 2 clocks after the baud rising edge sampling mid-stop.
// Backpressure: none; dout/frame_err are overwritten by each new frame.
// Ports: clock, reset (async active-high), baud (tick square wave),
//        rx (serial line, idle high), dout (last byte), rx_done_tick (1-clk
//        pulse with dout update), frame_err (stop bit sampled low).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            baud,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int            NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
    localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Baud edge detector: one-clock tick per rising edge of baud.
    logic baud_q;
    logic baud_q2;
    logic tick;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baud_q  <= 1'b0;
            baud_q2 <= 1'b0;
        end else begin
            baud_q  <= baud;
            baud_q2 <= baud_q;
        end
    end

    assign tick = baud_q & ~baud_q2;

    state_t            state_q, state_d;
    logic [3:0]        s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   dout_q, dout_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_done_tick_q, rx_done_tick_d;
    // settle counts the clocks until rx_s reflects the real line again after
    // reset (the synchronizer is forced high); armed is set once the real
    // line has been seen high in IDLE, so a frame cut by reset is not decoded.
    logic [1:0]        settle_q, settle_d;
    logic              armed_q, armed_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            s_q            <= '0;
            n_q            <= '0;
            b_q            <= '0;
            dout_q         <= '0;
            frame_err_q    <= 1'b0;
            rx_done_tick_q <= 1'b0;
            settle_q       <= 2'd0;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_q            <= s_d;
            n_q            <= n_d;
            b_q            <= b_d;
            dout_q         <= dout_d;
            frame_err_q    <= frame_err_d;
            rx_done_tick_q <= rx_done_tick_d;
            settle_q       <= settle_d;
            armed_q        <= armed_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        s_d            = s_q;
        n_d            = n_q;
        b_d            = b_q;
        dout_d         = dout_q;
        frame_err_d    = frame_err_q;
        rx_done_tick_d = 1'b0;
        settle_d       = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d        = armed_q;

        unique case (state_q)
            IDLE: begin
                if ((settle_q == 2'd2) && rx_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == START_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            state_d = IDLE;
                            s_d     = s_q + 4'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == SB_LAST) begin
                        dout_d         = b_q;
                        frame_err_d    = ~rx_s;
                        rx_done_tick_d = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign frame_err    = frame_err_q;
    assign rx_done_tick = rx_done_tick_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a scoreboard of expected {frame_err, dout}.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int BAUD_HALF = 164;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       baud  = 1'b0;
    logic       rx    = 1'b0;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    int total  = 0;
    int bad    = 0;
    int pulses = 0;

    // Expected results as {frame_err, dout}.
    logic [8:0] exp_q[$];
    logic [8:0] exp_v;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .baud         (baud),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            repeat (BAUD_HALF) @(negedge clock);
            baud = ~baud;
        end
    end

    // Output monitor: pops the scoreboard on every pulse, checks pulse width
    // and that outputs never move outside a pulse cycle.
    logic [7:0] last_dout = 8'h00;
    logic       last_fe   = 1'b0;
    logic       prev_done = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            last_dout = dout;
            last_fe   = frame_err;
            prev_done = 1'b0;
        end else begin
            if (rx_done_tick) begin
                pulses++;
                total++;
                assert (prev_done === 1'b0) else begin
                    bad++;
                    $error("FAIL done_width: pulse high=%b for 2 clocks, required single clock", prev_done);
                end
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_pulse: dout=%h fe=%b, required no pulse", dout, frame_err);
                end
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    total++;
                    assert ({frame_err, dout} === exp_v) else begin
                        bad++;
                        $error("FAIL frame: got fe=%b dout=%h, required fe=%b dout=%h",
                               frame_err, dout, exp_v[8], exp_v[7:0]);
                    end
                end
            end
            if (dout !== last_dout || frame_err !== last_fe) begin
                total++;
                assert (rx_done_tick === 1'b1) else begin
                    bad++;
                    $error("FAIL out_stable: dout %h->%h fe %b->%b with done=%b, required done=1",
                           last_dout, dout, last_fe, frame_err, rx_done_tick);
                end
            end
            last_dout = dout;
            last_fe   = frame_err;
            prev_done = rx_done_tick;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h required=%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int k);
        repeat (k) @(posedge baud);
    endtask

    task automatic send_bit(input logic v, input int k);
        rx = v;
        tick_n(k);
    endtask

    // A bad stop bit is held low only past its midpoint, then the line idles,
    // so the receiver does not mistake the tail of it for a new start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic push);
        if (push) exp_q.push_back({~stop_ok, d});
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        if (stop_ok) begin
            send_bit(1'b1, 16);
        end else begin
            send_bit(1'b0, 12);
            send_bit(1'b1, 4);
        end
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        repeat (4) @(negedge clock);
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL %s: %0d frames still pending, required 0", tag, exp_q.size());
        end
    endtask

    initial begin
        int  p;
        logic left_idle;

        // Reset with the line low: synchronizer must still read high.
        reset = 1'b1;
        rx    = 1'b0;
        repeat (5) @(negedge clock);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_done", 32'(rx_done_tick), 32'h0);
        check("rst_fe", 32'(frame_err), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_sync", 32'(dut.rx_s), 32'h1);
        rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tick_n(4);

        // Single good frame.
        p = pulses;
        send_frame(8'h55, 1'b1, 1'b1);
        wait_drain("drain_55");
        check("pulses_55", 32'(pulses), 32'(p + 1));
        check("fe_55", 32'(frame_err), 32'h0);

        // Back-to-back frames.
        p = pulses;
        send_frame(8'hA3, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b1);
        wait_drain("drain_b2b");
        check("pulses_b2b", 32'(pulses), 32'(p + 2));
        check("dout_b2b", 32'(dout), 32'h0F);

        // Start-bit glitch shorter than half a bit.
        p = pulses;
        rx = 1'b0;
        tick_n(4);
        rx = 1'b1;
        tick_n(20);
        check("glitch_state", 32'(dut.state_q), 32'(IDLE));
        check("glitch_pulses", 32'(pulses), 32'(p));
        check("glitch_dout", 32'(dout), 32'h0F);

        // Framing error, then recovery.
        send_frame(8'hC6, 1'b0, 1'b1);
        wait_drain("drain_c6");
        check("fe_c6", 32'(frame_err), 32'h1);
        check("dout_c6", 32'(dout), 32'hC6);
        tick_n(16);
        send_frame(8'h12, 1'b1, 1'b1);
        wait_drain("drain_12");
        check("fe_12", 32'(frame_err), 32'h0);

        // Reset in the middle of bit 3 of an 0xFF frame.
        p = pulses;
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
        send_bit(1'b1, 5);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_dout", 32'(dout), 32'h0);
        check("mid_rst_done", 32'(rx_done_tick), 32'h0);
        check("mid_rst_fe", 32'(frame_err), 32'h0);
        check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        check("mid_rst_b", 32'(dut.b_q), 32'h0);
        check("mid_rst_s", 32'(dut.s_q), 32'h0);
        check("mid_rst_n", 32'(dut.n_q), 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        send_bit(1'b1, 11);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        check("mid_rst_pulses", 32'(pulses), 32'(p));
        send_frame(8'h81, 1'b1, 1'b1);
        wait_drain("drain_81");
        check("dout_81", 32'(dout), 32'h81);
        check("pulses_81", 32'(pulses), 32'(p + 1));

        // Idle line with baud running.
        p = pulses;
        left_idle = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge baud);
            @(negedge clock);
            if (dut.state_q != IDLE) left_idle = 1'b1;
        end
        check("idle_state", 32'(left_idle), 32'h0);
        check("idle_pulses", 32'(pulses), 32'(p));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
